memory_arbiter: RTL and testbench

//  Arbitrates the single RAM port between the instruction-fetch and data requesters.

---
 rtl/memory_arbiter.sv | 163 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access.
// Each access is bounded by a timeout counter.
// Optional feature macro: MEM_ARB_RR_EN.
//   Defined: a token alternates tie priority between the two sides.
//   Undefined: data always wins ties.
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic w_iReq;
    logic w_dReq;
    logic w_serving;
    logic w_ownerReq;
    logic w_access;
    logic w_error;
    logic w_finish;
    logic w_timeout;
    logic w_complete;
    logic w_abort;
    logic w_dataWinsTie;

    assign w_iReq     = iREN;
    assign w_dReq     = dREN | dWEN;
    assign w_serving  = (r_state != IDLE);
    assign w_ownerReq = ((r_state == ISERV) & w_iReq) | ((r_state == DSERV) & w_dReq);
    assign w_access   = (ramstate == 2'd2);
    assign w_error    = (ramstate == 2'd3);

    // A finish returns RAM data; a timeout forces completion with no data.
    assign w_finish   = w_serving & w_ownerReq & (w_access | w_error);
    assign w_timeout  = w_serving & w_ownerReq & ~w_access & ~w_error & (r_cnt == LAST_CNT);
    assign w_complete = w_finish | w_timeout;
    assign w_abort    = w_serving & ~w_ownerReq;

`ifdef MEM_ARB_RR_EN
    // Token: 0 gives data priority, 1 gives instruction priority.
    logic r_token;

    // Hand priority to the other side after every completed (not aborted) access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_token <= 1'b0;
        end else if (w_complete) begin
            r_token <= (r_state == DSERV);
        end
    end

    assign w_dataWinsTie = ~r_token;
`else
    assign w_dataWinsTie = 1'b1;
`endif

    // State register, timeout counter and registered error pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= (w_serving && !w_complete && !w_abort) ? r_cnt + 1'b1 : '0;
            r_err   <= w_timeout | (w_finish & w_error);
        end
    end

    // Grant from IDLE; every service returns to IDLE, forcing one turnaround cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_dReq && (!w_iReq || w_dataWinsTie)) begin
                    w_nextState = DSERV;
                end else if (w_iReq) begin
                    w_nextState = ISERV;
                end else begin
                    w_nextState = IDLE;
                end
            end
            ISERV, DSERV: begin
                if (w_complete || w_abort) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Route the owner's request to the RAM and steer completion back to it.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = w_iReq;
        dwait    = w_dReq;
        case (r_state)
            ISERV: begin
                ramREN  = iREN & ~w_timeout;
                ramaddr = iaddr;
                if (w_complete) begin
                    iwait = 1'b0;
                end
                if (w_finish) begin
                    iload = ramload;
                end
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN & ~w_timeout;
                ramREN   = dREN & ~dWEN & ~w_timeout;
                if (w_complete) begin
                    dwait = 1'b0;
                end
                if (w_finish) begin
                    dload = ramload;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign err = r_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: cycle-by-cycle vectors for memory_arbiter (TIMEOUT_CYCLES=4).
// Inputs are driven on the falling edge and outputs checked 1ns later.
module tb_memory_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int errors = 0;
    int checks = 0;
    int vecIdx = 0;

    typedef struct {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
        logic        eIwait;
        logic [31:0] eIload;
        logic        eDwait;
        logic [31:0] eDload;
        logic        eRen;
        logic        eWen;
        logic [31:0] eAddr;
        logic [31:0] eStore;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    memory_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
        input logic [31:0] rl, input logic [1:0] rs,
        input logic eiw, input logic [31:0] eil, input logic edw, input logic [31:0] edl,
        input logic eren, input logic ewen, input logic [31:0] ea, input logic [31:0] es,
        input logic eerr);
        vec_t v;
        v.rst = rst;  v.iren = ir;  v.iaddr = ia;
        v.dren = dr;  v.dwen = dw;  v.daddr = da;  v.dstore = ds;
        v.ramload = rl;  v.ramstate = rs;
        v.eIwait = eiw;  v.eIload = eil;  v.eDwait = edw;  v.eDload = edl;
        v.eRen = eren;  v.eWen = ewen;  v.eAddr = ea;  v.eStore = es;
        v.eErr = eerr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        RST      = v.rst;
        iREN     = v.iren;
        iaddr    = v.iaddr;
        dREN     = v.dren;
        dWEN     = v.dwen;
        daddr    = v.daddr;
        dstore   = v.dstore;
        ramload  = v.ramload;
        ramstate = v.ramstate;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput($sformatf("v%0d.iwait", vecIdx), {31'd0, iwait}, {31'd0, v.eIwait});
        checkOutput($sformatf("v%0d.iload", vecIdx), iload, v.eIload);
        checkOutput($sformatf("v%0d.dwait", vecIdx), {31'd0, dwait}, {31'd0, v.eDwait});
        checkOutput($sformatf("v%0d.dload", vecIdx), dload, v.eDload);
        checkOutput($sformatf("v%0d.ramREN", vecIdx), {31'd0, ramREN}, {31'd0, v.eRen});
        checkOutput($sformatf("v%0d.ramWEN", vecIdx), {31'd0, ramWEN}, {31'd0, v.eWen});
        checkOutput($sformatf("v%0d.ramaddr", vecIdx), ramaddr, v.eAddr);
        checkOutput($sformatf("v%0d.ramstore", vecIdx), ramstore, v.eStore);
        checkOutput($sformatf("v%0d.err", vecIdx), {31'd0, err}, {31'd0, v.eErr});
    endtask

    // Apply each queued vector for one cycle, check, then empty the queue.
    task automatic runVectors();
        foreach (vecs[k]) begin
            @(negedge CLK);
            applyStimulus(vecs[k]);
            #1;
            checkVector(vecs[k]);
            vecIdx++;
        end
        vecs.delete();
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) @(posedge CLK);

        $display("[TB] single-cycle vectors: fetch, ERROR, abort, reset mid-service");
        //               rst ir ia        dr dw da        ds        rload          rs    iw  iload          dw  dload  REN WEN addr      store     err
        vecs.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h40,   0, 0, 32'h0,    32'h0,    32'h0,         FREE, 1, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h40,   0, 0, 32'h0,    32'h0,    32'hDEADBEEF,  ACC,  0, 32'hDEADBEEF,  0, 32'h0, 1, 0, 32'h40,   32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h80,   0, 0, 32'h0,    32'h0,    32'h0,         FREE, 1, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h80,   0, 0, 32'h0,    32'h0,    32'h12345678,  ERR,  0, 32'h12345678,  0, 32'h0, 1, 0, 32'h80,   32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    1));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,    1, 0, 32'h100,  32'hAAAA, 32'h0,         FREE, 0, 32'h0,         1, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,    1, 0, 32'h100,  32'hAAAA, 32'h0,         BUSY, 0, 32'h0,         1, 32'h0, 1, 0, 32'h100,  32'hAAAA, 0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h100,  32'hAAAA, 32'h0,         BUSY, 0, 32'h0,         0, 32'h0, 0, 0, 32'h100,  32'hAAAA, 0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h200,  0, 0, 32'h0,    32'h0,    32'h0,         FREE, 1, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h200,  0, 0, 32'h0,    32'h0,    32'h0,         BUSY, 1, 32'h0,         0, 32'h0, 1, 0, 32'h200,  32'h0,    0));
        vecs.push_back(mk(1, 1, 32'h200,  0, 0, 32'h0,    32'h0,    32'h0,         BUSY, 1, 32'h0,         0, 32'h0, 1, 0, 32'h200,  32'h0,    0));
        vecs.push_back(mk(1, 1, 32'h200,  0, 0, 32'h0,    32'h0,    32'h0,         BUSY, 1, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        runVectors();

        $display("[TB] timeout: data write with RAM stuck BUSY");
        vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h300,  32'h55,   32'hFFFF,      BUSY, 0, 32'h0,         1, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        for (int c = 0; c < 3; c++) begin
            vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h300, 32'h55,   32'hFFFF,      BUSY, 0, 32'h0,         1, 32'h0, 0, 1, 32'h300,  32'h55,   0));
        end
        vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h300,  32'h55,   32'hFFFF,      BUSY, 0, 32'h0,         0, 32'h0, 0, 0, 32'h300,  32'h55,   0));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    1));
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        runVectors();

        $display("[TB] tie between instruction read and data write");
        vecs.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h400,  0, 1, 32'h500,  32'h77,   32'hCAFE,      ACC,  1, 32'h0,         1, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h400,  0, 1, 32'h500,  32'h77,   32'hCAFE,      ACC,  1, 32'h0,         0, 32'hCAFE, 0, 1, 32'h500, 32'h77, 0));
`ifdef MEM_ARB_RR_EN
        for (int a = 0; a < 3; a++) begin
            vecs.push_back(mk(0, 1, 32'h400, 0, 1, 32'h500, 32'h77, 32'hCAFE,    ACC,  1, 32'h0,         1, 32'h0, 0, 0, 32'h0,    32'h0,    0));
            if (a % 2 == 0) begin
                vecs.push_back(mk(0, 1, 32'h400, 0, 1, 32'h500, 32'h77, 32'hCAFE, ACC, 0, 32'hCAFE,   1, 32'h0, 1, 0, 32'h400,  32'h0,    0));
            end else begin
                vecs.push_back(mk(0, 1, 32'h400, 0, 1, 32'h500, 32'h77, 32'hCAFE, ACC, 1, 32'h0,      0, 32'hCAFE, 0, 1, 32'h500, 32'h77, 0));
            end
        end
`else
        vecs.push_back(mk(0, 1, 32'h400,  0, 0, 32'h500,  32'h77,   32'hCAFE,      ACC,  1, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h400,  0, 0, 32'h500,  32'h77,   32'hCAFE,      ACC,  0, 32'hCAFE,      0, 32'h0, 1, 0, 32'h400,  32'h0,    0));
`endif
        vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,    32'h0,         FREE, 0, 32'h0,         0, 32'h0, 0, 0, 32'h0,    32'h0,    0));
        runVectors();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
